// File: rtl/vp_mac_sequencer.sv
// vp_mac_sequencer: feeds a MAC slave with precision, scale and operand beats per command,
// then collects the MAC result and hands it out on the result port.
module vp_mac_sequencer #(
    parameter int AXIS_DW = 32,
    parameter int LEN_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [3:0]         i_cmd_precision,
    input  logic [31:0]        i_cmd_scale,
    input  logic [LEN_W-1:0]   i_cmd_len,
    input  logic [15:0]        i_op_tdata,
    input  logic               i_op_tvalid,
    output logic               o_op_tready,
    output logic [AXIS_DW-1:0] o_mo_tdata,
    output logic               o_mo_tuser,
    output logic               o_mo_tlast,
    output logic [7:0]         o_mo_tid,
    output logic               o_mo_tvalid,
    input  logic               i_mo_tready,
    input  logic [AXIS_DW-1:0] i_rs_tdata,
    input  logic               i_rs_tlast,
    input  logic               i_rs_tvalid,
    output logic               o_rs_tready,
    output logic [AXIS_DW-1:0] o_ro_tdata,
    output logic               o_ro_tvalid,
    input  logic               i_ro_tready,
    output logic               o_busy,
    output logic               o_err
);
    typedef enum logic [2:0] {IDLE, SEND_PREC, SEND_SCALE, SEND_DATA, WAIT_RES, DELIVER} state_t;
    state_t             r_state, w_next;
    logic [3:0]         r_prec;
    logic [31:0]        r_scale;
    logic [LEN_W-1:0]   r_len, r_cnt;
    logic [AXIS_DW-1:0] r_result;
    logic               r_err, w_err, w_cmd_bad, w_last, w_mo_hs;
    assign w_cmd_bad = (i_cmd_precision > 4'd8) | (i_cmd_len == '0);
    assign w_last    = r_cnt == r_len - LEN_W'(1);
    assign w_mo_hs   = i_op_tvalid & i_mo_tready;
    assign o_ro_tdata = r_result;
    assign o_busy     = r_state != IDLE;
    assign o_err      = r_err;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_prec   <= '0;
            r_scale  <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err;
            if (r_state == IDLE && i_cmd_valid) begin
                r_prec  <= i_cmd_precision;
                r_scale <= i_cmd_scale;
                r_len   <= i_cmd_len;
            end
            if (r_state == SEND_SCALE)
                r_cnt <= '0;
            else if (r_state == SEND_DATA && w_mo_hs)
                r_cnt <= r_cnt + LEN_W'(1);
            if (r_state == WAIT_RES && i_rs_tvalid)
                r_result <= i_rs_tdata;
        end
    end
    // Command port is held off while reset is asserted, even though the state is already IDLE.
    always_comb begin
        w_next      = r_state;
        w_err       = 1'b0;
        o_cmd_ready = 1'b0;
        o_op_tready = 1'b0;
        o_mo_tdata  = '0;
        o_mo_tuser  = 1'b0;
        o_mo_tlast  = 1'b0;
        o_mo_tid    = '0;
        o_mo_tvalid = 1'b0;
        o_rs_tready = 1'b0;
        o_ro_tvalid = 1'b0;
        case (r_state)
            IDLE: begin
                o_cmd_ready = ~i_rst;
                if (i_cmd_valid) begin
                    w_err  = w_cmd_bad;
                    w_next = w_cmd_bad ? IDLE : SEND_PREC;
                end
            end
            SEND_PREC: begin
                o_mo_tvalid = 1'b1;
                o_mo_tdata  = AXIS_DW'(r_prec);
                o_mo_tuser  = 1'b1;
                w_next      = i_mo_tready ? SEND_SCALE : SEND_PREC;
            end
            SEND_SCALE: begin
                o_mo_tvalid = 1'b1;
                o_mo_tdata  = AXIS_DW'(r_scale);
                w_next      = i_mo_tready ? SEND_DATA : SEND_SCALE;
            end
            SEND_DATA: begin
                o_mo_tvalid = i_op_tvalid;
                o_op_tready = i_mo_tready;
                o_mo_tdata  = AXIS_DW'(i_op_tdata);
                o_mo_tlast  = w_last;
                o_mo_tid    = r_cnt[7:0];
                w_next      = (w_mo_hs && w_last) ? WAIT_RES : SEND_DATA;
            end
            WAIT_RES: begin
                o_rs_tready = 1'b1;
                if (i_rs_tvalid) begin
                    w_next = DELIVER;
                    w_err  = ~i_rs_tlast;
                end
            end
            DELIVER: begin
                o_ro_tvalid = 1'b1;
                w_next      = i_ro_tready ? IDLE : DELIVER;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: doc/vp_mac_sequencer.md
VP_MAC_SEQUENCER -- requirements
Module: vp_mac_sequencer

Interface
REQ-001 SHALL have parameter AXIS_DW, default 32, MAC stream data width.
REQ-002 SHALL have parameter LEN_W, default 16, width of the command beat count.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 CLK  in  1  sole clock, all state on rising edge.
REQ-005 RESET  in  1  asynchronous active-high reset.
REQ-006 CMD_VALID / CMD_READY  in / out  1 / 1  command handshake.
REQ-007 CMD_PRECISION  in  4  MAC precision level (legal 0..8).
REQ-008 CMD_SCALE  in  32  Q16.16 dequant scale word.
REQ-009 CMD_LEN  in  LEN_W  operand beats per job (legal >= 1).
REQ-010 OP_TDATA / OP_TVALID / OP_TREADY  in / in / out  16 / 1 / 1  operand stream {activation[15:8], weight[7:0]}.
REQ-011 MO_TDATA / MO_TUSER / MO_TLAST / MO_TID / MO_TVALID  out  AXIS_DW / 1 / 1 / 8 / 1  stream to MAC slave port.
REQ-012 MO_TREADY  in  1  MAC slave ready.
REQ-013 RS_TDATA / RS_TLAST / RS_TVALID  in  AXIS_DW / 1 / 1  MAC result stream; RS_TREADY out 1.
REQ-014 RO_TDATA / RO_TVALID  out  AXIS_DW / 1  job result; RO_TREADY in 1.
REQ-015 BUSY  out  1  high in any state but IDLE; ERR  out  1  one-cycle error pulse.

Function
REQ-016 SHALL implement FSM states IDLE, SEND_PREC, SEND_SCALE, SEND_DATA, WAIT_RES, DELIVER.
REQ-017 IDLE: CMD_READY=1; on CMD handshake latch precision, scale, len; if precision>8 or len==0 pulse ERR next cycle, stay IDLE, emit no MAC traffic; else go SEND_PREC.
REQ-018 SEND_PREC: MO_TVALID=1, MO_TDATA={zero-extend precision}, MO_TUSER=1, MO_TLAST=0, MO_TID=0; on MO_TREADY go SEND_SCALE.
REQ-019 SEND_SCALE: MO_TVALID=1, MO_TDATA=scale, MO_TUSER=0, MO_TLAST=0, MO_TID=0; on MO_TREADY go SEND_DATA, beat counter cleared to 0.
REQ-020 SEND_DATA: combinational pass-through, MO_TVALID=OP_TVALID, OP_TREADY=MO_TREADY, MO_TDATA={16'h0, OP_TDATA}, MO_TUSER=0, MO_TID=counter[7:0] (wraps mod 256).
REQ-021 MO_TLAST SHALL be 1 only on the beat where counter==len-1; counter increments on each MO handshake; on the TLAST handshake go WAIT_RES.
REQ-022 OP_TREADY SHALL be 0 in all states other than SEND_DATA; no operand is consumed outside a job.
REQ-023 In SEND_PREC/SEND_SCALE, MO_TDATA/TUSER/TID SHALL remain stable while MO_TVALID=1 and MO_TREADY=0.
REQ-024 WAIT_RES: RS_TREADY=1; on RS handshake capture RS_TDATA into result register, go DELIVER; if RS_TLAST=0 also pulse ERR (result still delivered).
REQ-025 RS_TREADY SHALL be 0 outside WAIT_RES.
REQ-026 DELIVER: RO_TVALID=1, RO_TDATA=result register stable until RO_TREADY; on handshake go IDLE.
REQ-027 New command SHALL be accepted no earlier than the cycle after DELIVER handshake (CMD_READY low while BUSY).
REQ-028 Counter SHALL be LEN_W bits; len=2^LEN_W-1 SHALL complete without overflow.
REQ-029 ERR SHALL be a single-cycle pulse, never held.

Reset
REQ-030 RESET assertion SHALL immediately force IDLE, counter=0, result register=0, all latched command fields=0.
REQ-031 During and after reset: MO_TVALID=0, MO_TLAST=0, MO_TUSER=0, MO_TID=0, MO_TDATA=0, OP_TREADY=0, RS_TREADY=0, RO_TVALID=0, RO_TDATA=0, BUSY=0, ERR=0, CMD_READY=0 while RESET high, 1 the first cycle after release.
REQ-032 Reset mid-job SHALL abandon the job with no further MAC beats; the bench resets the MAC concurrently.

Verification
REQ-033 Cmd prec=3, scale=0x0000009C, len=10, MO_TREADY=1 -> MAC sees prec beat (TUSER=1, data 3), scale beat (data 0x9C), 10 data beats TID 0..9, TLAST only on TID 9.
REQ-034 Same job with random MO_TREADY/OP_TVALID -> config beats held stable while stalled; exactly 10 operands consumed; no data beat duplicated or dropped.
REQ-035 Cmd prec=9 or len=0 -> ERR pulses once, BUSY stays 0, MO_TVALID never asserts, CMD_READY remains 1.
REQ-036 RS returns 0xA1B2C3D4 with TLAST=1, RO_TREADY low 5 cycles -> RO_TVALID high with stable 0xA1B2C3D4, FSM back to IDLE after handshake; with TLAST=0 -> ERR pulse plus same delivery.
REQ-037 len=300 -> MO_TID wraps 255->0, TLAST on 300th beat only.
REQ-038 RESET asserted during SEND_DATA beat 4 -> all outputs at reset values same cycle; next command runs from SEND_PREC normally.
